// File: rtl/sweep_controller.sv
// Sweep sequencer for a 4-bit up/down counter: loads the start value, then
// steps toward each leg's endpoint at a divided rate, bouncing for the programmed legs.
module sweep_controller #(
  parameter int WIDTH = 4,
  parameter int DIVW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] start_value,
  input  logic [WIDTH-1:0] end_value,
  input  logic [3:0]       legs,
  input  logic [DIVW-1:0]  step_div,
  input  logic [WIDTH-1:0] count,
  output logic             ctr_enable,
  output logic             ctr_set,
  output logic [WIDTH-1:0] ctr_set_value,
  output logic             ctr_up_down,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_start;
  logic [WIDTH-1:0] r_end;
  logic [WIDTH-1:0] r_target;
  logic [3:0]       r_legs_left;
  logic [DIVW-1:0]  r_div;
  logic [DIVW-1:0]  r_presc;
  logic             r_dir;
  logic             w_match;
  logic             w_last;

  assign w_match = (count == r_target);
  assign w_last  = (r_legs_left <= 4'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (start) w_next = S_LOAD;
        S_LOAD: w_next = S_RUN;
        S_RUN:  if (w_match && w_last) w_next = S_DONE;
        S_DONE: w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_start     <= '0;
      r_end       <= '0;
      r_target    <= '0;
      r_legs_left <= '0;
      r_div       <= '0;
      r_presc     <= '0;
      r_dir       <= 1'b1;
    end else if (!abort) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_start     <= start_value;
            r_end       <= end_value;
            r_target    <= end_value;
            r_dir       <= (end_value >= start_value);
            r_legs_left <= (legs == 4'd0) ? 4'd1 : legs;
            r_div       <= step_div;
          end
        end
        S_LOAD: r_presc <= r_div;
        S_RUN: begin
          // Turnaround swaps endpoints; when start==end both endpoints are equal anyway.
          if (w_match && !w_last) begin
            r_target    <= (r_target == r_end) ? r_start : r_end;
            r_dir       <= ~r_dir;
            r_legs_left <= r_legs_left - 4'd1;
            r_presc     <= r_div;
          end else if (!w_match) begin
            if (r_presc == '0) r_presc <= r_div;
            else               r_presc <= r_presc - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ctr_enable    = 1'b0;
    ctr_set       = (r_state == S_LOAD);
    ctr_set_value = r_start;
    ctr_up_down   = r_dir;
    busy          = (r_state == S_LOAD) || (r_state == S_RUN);
    done          = (r_state == S_DONE) && !abort;
    case (r_state)
      S_LOAD: ctr_enable = !abort;
      S_RUN:  ctr_enable = !abort && !w_match && (r_presc == '0);
      default: ctr_enable = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_sweep_controller.sv
// Scoreboard bench: a counter model closes the loop; a reference model predicts
// load/step/done events with their cycle numbers, a monitor pops and compares.
module tb_sweep_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] start_value = '0;
  logic [3:0] end_value = '0;
  logic [3:0] legs = '0;
  logic [3:0] step_div = '0;
  logic [3:0] count = '0;
  logic       ctr_enable, ctr_set, ctr_up_down, busy, done;
  logic [3:0] ctr_set_value;

  sweep_controller #(.WIDTH(4), .DIVW(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .start_value(start_value), .end_value(end_value), .legs(legs),
    .step_div(step_div), .count(count), .ctr_enable(ctr_enable),
    .ctr_set(ctr_set), .ctr_set_value(ctr_set_value),
    .ctr_up_down(ctr_up_down), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Controlled 4-bit up/down counter
  always @(posedge clk)
    if (ctr_enable) count <= ctr_set ? ctr_set_value : (ctr_up_down ? count + 4'd1 : count - 4'd1);

  typedef enum int {EV_LOAD, EV_STEP, EV_DONE, EV_PROBE} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    int         cyc;
    logic [3:0] val;
    logic       dir;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  bit  finished = 1'b0;

  // Monitor: samples on the falling edge, away from input changes and clock edges
  always @(negedge clk) begin
    ev_t      ev;
    ev_kind_t k;
    bit       seen;
    logic [3:0] oval;
    if (!reset) begin
      n_cmp++;
      if ({ctr_enable, ctr_set, ctr_set_value, ctr_up_down, busy, done} !== 9'b0_0_0000_1_0_0) begin
        n_err++;
        $display("FAIL reset_outputs cyc=%0d got en=%b set=%b sv=%0d ud=%b busy=%b done=%b required en=0 set=0 sv=0 ud=1 busy=0 done=0",
                 cyc, ctr_enable, ctr_set, ctr_set_value, ctr_up_down, busy, done);
      end
    end else begin
      while (exp_q.size() > 0 && exp_q[0].kind == EV_PROBE && exp_q[0].cyc <= cyc) begin
        ev = exp_q.pop_front();
        n_cmp++;
        if (count !== ev.val || busy !== 1'b0) begin
          n_err++;
          $display("FAIL idle_probe cyc=%0d got count=%0d busy=%b required count=%0d busy=0",
                   cyc, count, busy, ev.val);
        end
      end
      seen = 1'b1;
      k    = EV_DONE;
      if (ctr_enable && ctr_set)  k = EV_LOAD;
      else if (ctr_enable)        k = EV_STEP;
      else if (done)              k = EV_DONE;
      else                        seen = 1'b0;
      oval = (k == EV_LOAD) ? ctr_set_value : count;
      if (seen) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event cyc=%0d got kind=%0d val=%0d required no event", cyc, k, oval);
        end else begin
          ev = exp_q.pop_front();
          if (ev.kind != k || ev.cyc != cyc ||
              (k != EV_DONE && ev.val !== oval) ||
              (k == EV_STEP && ev.dir !== ctr_up_down) ||
              (k == EV_DONE && busy !== 1'b0)) begin
            n_err++;
            $display("FAIL event cyc=%0d got kind=%0d val=%0d ud=%b busy=%b required kind=%0d cyc=%0d val=%0d ud=%b",
                     cyc, k, oval, ctr_up_down, busy, ev.kind, ev.cyc, ev.val, ev.dir);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].kind != EV_PROBE && exp_q[0].cyc <= cyc) begin
        ev = exp_q.pop_front();
        n_cmp++;
        n_err++;
        $display("FAIL missed_event cyc=%0d got none required kind=%0d at cyc=%0d val=%0d",
                 cyc, ev.kind, ev.cyc, ev.val);
      end
    end
    if (finished) begin
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_err++;
        $display("FAIL leftover_events got %0d pending required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input ev_kind_t k, input int c, input logic [3:0] v, input logic d);
    ev_t ev;
    ev.kind = k; ev.cyc = c; ev.val = v; ev.dir = d;
    exp_q.push_back(ev);
  endtask

  // Reference: leg l runs from one endpoint to the other; within a leg step k
  // lands at leg_start + div + k*(div+1); the match cycle follows the last step.
  task automatic push_sweep(input logic [3:0] s_v, input logic [3:0] e_v, input logic [3:0] lg,
                            input logic [3:0] dv, input int base, output int fin);
    int n, nl, c, per, m;
    logic [3:0] from;
    logic up;
    n   = (e_v >= s_v) ? int'(e_v) - int'(s_v) : int'(s_v) - int'(e_v);
    nl  = (lg == 4'd0) ? 1 : int'(lg);
    per = int'(dv) + 1;
    c   = base + 1;
    fin = base;
    push(EV_LOAD, base, s_v, 1'b0);
    for (int l = 0; l < nl; l++) begin
      from = (l % 2 == 0) ? s_v : e_v;
      up   = (l % 2 == 0) ? (e_v >= s_v) : (s_v >= e_v);
      for (int k = 0; k < n; k++)
        push(EV_STEP, c + int'(dv) + k * per, up ? 4'(int'(from) + k) : 4'(int'(from) - k), up);
      m = c + n * per;
      if (l == nl - 1) begin
        push(EV_DONE, m + 1, 4'd0, 1'b0);
        fin = m + 1;
      end else begin
        c = m + 1;
      end
    end
  endtask

  task automatic run_sweep(input logic [3:0] s_v, input logic [3:0] e_v, input logic [3:0] lg,
                           input logic [3:0] dv, input bit stray, input int abort_at,
                           input int probe_val);
    int base, fin;
    start_value = s_v; end_value = e_v; legs = lg; step_div = dv;
    start = 1'b1;
    base  = cyc + 1;
    push_sweep(s_v, e_v, lg, dv, base, fin);
    tick();
    start = 1'b0;
    start_value = 4'($urandom); end_value = 4'($urandom);
    legs = 4'($urandom); step_div = 4'($urandom);
    while (cyc < fin + 3) begin
      if (abort_at >= 0 && cyc == base + abort_at) begin
        abort = 1'b1;
        while (exp_q.size() > 0 && exp_q[$].cyc >= cyc) void'(exp_q.pop_back());
        if (probe_val >= 0) push(EV_PROBE, cyc + 3, 4'(probe_val), 1'b0);
      end else begin
        abort = 1'b0;
      end
      start = (stray && cyc == base + 2);
      tick();
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    int s_r, e_r, l_r, d_r, fin_r, base_r, ab;
    #1 reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    run_sweep(4'd3, 4'd6, 4'd1, 4'd0, 1'b0, -1, -1);
    run_sweep(4'd2, 4'd0, 4'd3, 4'd2, 1'b0, -1, -1);
    run_sweep(4'd9, 4'd9, 4'd0, 4'd0, 1'b0, -1, -1);
    run_sweep(4'd1, 4'd12, 4'd1, 4'd0, 1'b0, 5, 5);
    run_sweep(4'd4, 4'd11, 4'd2, 4'd1, 1'b1, -1, -1);

    // start together with abort in IDLE must not launch a sweep
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    repeat (4) tick();

    // asynchronous reset in the middle of a run
    start_value = 4'd0; end_value = 4'd15; legs = 4'd1; step_div = 4'd3; start = 1'b1;
    base_r = cyc + 1;
    push_sweep(4'd0, 4'd15, 4'd1, 4'd3, base_r, fin_r);
    tick();
    start = 1'b0;
    repeat (10) tick();
    reset = 1'b0;
    exp_q.delete();
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();

    run_sweep(4'd7, 4'd5, 4'd2, 4'd0, 1'b1, -1, -1);

    for (int i = 0; i < 25; i++) begin
      s_r = $urandom_range(0, 15);
      e_r = $urandom_range(0, 15);
      l_r = $urandom_range(0, 5);
      d_r = $urandom_range(0, 6);
      ab  = -1;
      if ($urandom_range(0, 4) == 0) begin
        base_r = cyc + 1;
        push_sweep(4'(s_r), 4'(e_r), 4'(l_r), 4'(d_r), base_r, fin_r);
        exp_q.delete();
        ab = $urandom_range(0, fin_r - base_r);
      end
      run_sweep(4'(s_r), 4'(e_r), 4'(l_r), 4'(d_r), 1'($urandom_range(0, 1)), ab, -1);
    end

    finished = 1'b1;
    repeat (5) tick();
    $display("FAIL monitor_end got no summary required summary");
    $fatal(1, "monitor did not finish");
  end

endmodule
